// File: rtl/rv32i_dmem_arbiter.sv
// rtl/rv32i_dmem_arbiter.sv - two-master round-robin arbiter/sequencer for the data-memory port
// Optional bus timeout abort: define RV32I_DMEM_ARB_TIMEOUT_EN.
module rv32i_dmem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_req,
  input  logic        i_core_we,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  input  logic [3:0]  i_core_mask,
  output logic        o_core_ack,
  output logic [31:0] o_core_rdata,
  output logic        o_core_stall,
  input  logic        i_aux_req,
  input  logic        i_aux_we,
  input  logic [31:0] i_aux_addr,
  input  logic [31:0] i_aux_wdata,
  input  logic [3:0]  i_aux_mask,
  output logic        o_aux_ack,
  output logic [31:0] o_aux_rdata,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_aux_q, last_aux_d;
  logic        gnt_aux_q, gnt_aux_d;
  logic        mem_stb_q, mem_stb_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        core_ack_q, core_ack_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic        aux_ack_q, aux_ack_d;
  logic [31:0] aux_rdata_q, aux_rdata_d;

  logic        any_req;
  logic        pick_aux;
  logic        timed_out;
  logic        complete;
  logic [31:0] rdata_ret;

  assign any_req  = i_core_req | i_aux_req;
  // On a tie the master that did not win last time gets the port.
  assign pick_aux = i_aux_req & (~i_core_req | ~last_aux_q);

`ifdef RV32I_DMEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // A real ack on the timeout edge wins and completes normally.
  assign timed_out = ~i_mem_ack & (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    case (state_q)
      S_IDLE:  cnt_d = 16'h0;
      S_BUSY: begin
        if (!complete) cnt_d = cnt_q + 16'h1;
        err_d = timed_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 16'h0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign timed_out = 1'b0;
  // TIMEOUT is at least 1, so this is a constant-0 tie.
  assign o_err     = (TIMEOUT == 0);
`endif

  assign complete  = i_mem_ack | timed_out;
  assign rdata_ret = (mem_we_q | timed_out) ? 32'h0 : i_mem_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_BUSY;
      S_BUSY:  if (complete) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_aux_d   = last_aux_q;
    gnt_aux_d    = gnt_aux_q;
    mem_stb_d    = mem_stb_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    core_ack_d   = 1'b0;
    core_rdata_d = core_rdata_q;
    aux_ack_d    = 1'b0;
    aux_rdata_d  = aux_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_aux_d   = pick_aux;
          last_aux_d  = pick_aux;
          mem_stb_d   = 1'b1;
          mem_we_d    = pick_aux ? i_aux_we    : i_core_we;
          mem_addr_d  = pick_aux ? i_aux_addr  : i_core_addr;
          mem_wdata_d = pick_aux ? i_aux_wdata : i_core_wdata;
          mem_mask_d  = pick_aux ? i_aux_mask  : i_core_mask;
        end
      end
      S_BUSY: begin
        if (complete) begin
          mem_stb_d = 1'b0;
          mem_we_d  = 1'b0;
          if (gnt_aux_q) begin
            aux_ack_d   = 1'b1;
            aux_rdata_d = rdata_ret;
          end else begin
            core_ack_d   = 1'b1;
            core_rdata_d = rdata_ret;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_aux_q   <= 1'b1;
      gnt_aux_q    <= 1'b0;
      mem_stb_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_mask_q   <= 4'h0;
      core_ack_q   <= 1'b0;
      core_rdata_q <= 32'h0;
      aux_ack_q    <= 1'b0;
      aux_rdata_q  <= 32'h0;
    end else begin
      last_aux_q   <= last_aux_d;
      gnt_aux_q    <= gnt_aux_d;
      mem_stb_q    <= mem_stb_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      aux_ack_q    <= aux_ack_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

  assign o_core_ack   = core_ack_q;
  assign o_core_rdata = core_rdata_q;
  assign o_core_stall = i_core_req & ~core_ack_q;
  assign o_aux_ack    = aux_ack_q;
  assign o_aux_rdata  = aux_rdata_q;
  assign o_mem_stb    = mem_stb_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_mask   = mem_mask_q;

endmodule

// File: doc/rv32i_dmem_arbiter.md
# rv32i_dmem_arbiter

Two-master arbiter and sequencer for the single data-memory port. It shares the port between the core's memory-access stage and an auxiliary master (debug/DMA). It serializes one transaction at a time, holds the memory strobe until the memory acknowledges, and stalls the core pipeline while the core's access is pending. Requesters get a registered one-cycle acknowledge with read data.

## Interface
- TIMEOUT, 255: BUSY cycles without `i_mem_ack` before abort. Used only with the configuration macro. Range 1..65535.

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_core_req  in  1  core request; held until `o_core_ack`
- i_core_we  in  1  1 = store, 0 = load
- i_core_addr  in  32  byte address
- i_core_wdata  in  32  store data, already mask-aligned
- i_core_mask  in  4  byte write mask {b3,b2,b1,b0}
- o_core_ack  out  1  one-cycle completion pulse
- o_core_rdata  out  32  load data, valid while `o_core_ack`=1
- o_core_stall  out  1  pipeline stall request to the core
- i_aux_req, i_aux_we, i_aux_addr, i_aux_wdata, i_aux_mask  in  1/1/32/32/4  auxiliary master; same meaning as the core ports
- o_aux_ack, o_aux_rdata  out  1/32  auxiliary completion and load data
- o_mem_stb  out  1  memory strobe; held until ack
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_mask  out  4  memory byte mask
- i_mem_ack  in  1  memory completion; sampled only in BUSY
- i_mem_rdata  in  32  memory read data, valid with `i_mem_ack`
- o_err  out  1  timeout abort pulse (0 when the feature is compiled out)

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - With a request, grant it, latch the granter's we/addr/wdata/mask into the `o_mem_*` registers, set `o_mem_stb`=1, and go to BUSY.
- Arbitration is round-robin. A `last_grant` bit records the most recent grantee.
  - When both masters request, grant the master that is not `last_grant`.
  - When one master requests, it is granted regardless of `last_grant`.
  - Reset value of `last_grant` is aux, so the core wins the first tie.
- BUSY:
  - `o_mem_*` are held constant.
  - On `i_mem_ack`=1: clear `o_mem_stb` and `o_mem_we`, and go to DONE.
    - The granted master's ack is set to 1.
    - Its rdata register loads `i_mem_rdata` for a load, or 32'h0 for a store.
- DONE: lasts exactly one cycle, with the granted master's ack high. It then goes to IDLE. Requests are not sampled in DONE.
- Requester rule: drop req, or present a new command, in the cycle ack is seen. Req still high in the following IDLE cycle is a new request.
- `o_core_stall` is combinational: `i_core_req & ~o_core_ack`. It therefore also covers cycles the core spends waiting for an aux transaction.
- Request and command inputs are ignored outside IDLE. `i_mem_ack` is ignored outside BUSY, so a stray or late ack has no effect.
- Non-granted master ack stays 0 and its rdata register holds its value.

## Timing
- Reset values: all outputs 0, `o_mem_*` 0, state IDLE.
- Reset mid-operation: state goes immediately to IDLE, `o_mem_stb` drops, and the in-flight transaction is abandoned with no ack.
- Latency:
  - Req seen at edge N gives `o_mem_stb`=1 after edge N.
  - Ack sampled at edge M gives the requester ack/rdata after edge M.
  - The arbiter returns to IDLE after edge M+1.
  - The minimum transaction is 3 cycles (req to ack-visible takes 2 edges when memory acks in the first BUSY cycle).
- Back-to-back throughput is 1 transaction per 3 cycles with a zero-wait memory.
- Both masters requesting at edge N: one is served, and the other is granted at the first IDLE edge after its rival's DONE.

## Configuration
- Macro `RV32I_DMEM_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, drop `o_mem_stb` and go to DONE. The granted master's ack pulses with rdata 32'h0, and `o_err` pulses 1 for the same cycle.
  - An ack arriving on the timeout edge itself takes priority and is a normal completion with no `o_err`.
- Undefined: no counter, BUSY waits indefinitely, and `o_err` is tied to 0.

## Test plan
- Core load, addr 0x100; memory acks in the first BUSY cycle with 0xCAFEBABE:
  - `o_mem_stb` is high for 1 cycle.
  - `o_core_ack`=1 with rdata 0xCAFEBABE exactly 2 edges after req.
  - `o_core_stall` is high for 2 cycles.
- Aux store, wdata 0x12345678, mask 4'b0011, memory acks after 3 wait cycles:
  - `o_mem_*` are stable for all 4 BUSY cycles.
  - `o_aux_ack` pulses once with rdata 0.
- Both masters request continuously from reset: grants go core, aux, core, aux, and each ack is separated by 3 cycles.
- Core waits while aux is in BUSY: `o_core_stall`=1 throughout, then the core is granted on the first IDLE edge after aux DONE.
- Assert `i_rst_n`=0 during BUSY: all outputs go to 0 immediately, no ack follows, and a new core req after release completes normally.
- With `RV32I_DMEM_ARB_TIMEOUT_EN` defined and TIMEOUT=4, memory never acks: after 4 BUSY cycles `o_err` and `o_core_ack` pulse together with rdata 0.
